// File: rtl/qif_neuron_array.sv
// ---------------------------------------------------------------------------
// qif_neuron_array
//   A bank of quadratic integrate-and-fire neurons that share one
//   time-multiplexed update datapath. A "step" pulse starts a sweep that
//   advances every neuron by one tick, one neuron per clock. The sweep then
//   publishes which neurons spiked and adds that number to a running total.
//
//   Membrane update (signed, evaluated at 2*WIDTH+2 bits):
//     V_next = sat( V + (I >>> B_SHIFT) + ((V*V) >>> FRAC_SHIFT) )
//   A neuron spikes when V_next >= V_PEAK. It then reloads V_RESET and stays
//   clamped at V_RESET for REFRACT further sweeps.
//
// Ports
//   clk        clock
//   rst_n      synchronous reset, active-low
//   ena        global enable; low freezes FSM, V, refractory, spike_cnt
//              (current-register writes are still accepted)
//   cur_we     write strobe for the per-neuron input-current register
//   cur_addr   neuron index for cur_data
//   cur_data   signed input current I
//   step       start one update sweep (sampled only when idle and enabled)
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a sweep completes; spike_vec valid
//   spike_vec  bit k set if neuron k spiked in the last completed sweep
//   spike_cnt  total spikes since reset, wraps at 2^16
//   v_mon_sel  membrane monitor select
//   v_mon      combinational V[v_mon_sel]
// ---------------------------------------------------------------------------
module qif_neuron_array #(
    parameter int WIDTH      = 8,
    parameter int N_NEURONS  = 4,
    parameter int V_RESET    = -20,
    parameter int V_PEAK     = 50,
    parameter int B_SHIFT    = 2,
    parameter int FRAC_SHIFT = 4,
    parameter int REFRACT    = 2,
    localparam int AW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cur_we,
    input  logic [AW-1:0]        cur_addr,
    input  logic [WIDTH-1:0]     cur_data,
    input  logic                 step,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic [15:0]          spike_cnt,
    input  logic [AW-1:0]        v_mon_sel,
    output logic [WIDTH-1:0]     v_mon
);

    // Extended width holds V*V plus both addends without overflow.
    localparam int EW = 2 * WIDTH + 2;
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int PW = $clog2(N_NEURONS + 1);

    localparam logic signed [EW-1:0]    MAX_E  = EW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [EW-1:0]    MIN_E  = EW'(-(2 ** (WIDTH - 1)));
    localparam logic signed [EW-1:0]    PEAK_E = EW'(V_PEAK);
    localparam logic signed [WIDTH-1:0] V_RST  = WIDTH'(V_RESET);
    localparam logic [RW-1:0]           REFR_LOAD = RW'(REFRACT);
    localparam logic [AW-1:0]           LAST_IDX  = AW'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                   state;
    logic [AW-1:0]            idx;
    logic [N_NEURONS-1:0]     shadow;
    logic signed [WIDTH-1:0]  v_mem    [N_NEURONS];
    logic signed [WIDTH-1:0]  cur_mem  [N_NEURONS];
    logic [RW-1:0]            refr_mem [N_NEURONS];

    // Datapath for the neuron currently selected by idx.
    logic signed [WIDTH-1:0] v_cur;
    logic signed [WIDTH-1:0] i_cur;
    logic [RW-1:0]           refr_cur;
    logic signed [EW-1:0]    v_e;
    logic signed [EW-1:0]    i_e;
    logic signed [EW-1:0]    sum;
    logic signed [EW-1:0]    sat;
    logic signed [WIDTH-1:0] v_upd;
    logic [RW-1:0]           refr_upd;
    logic                    spike_upd;
    logic [PW-1:0]           pop;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        v_cur     = v_mem[idx];
        i_cur     = cur_mem[idx];
        refr_cur  = refr_mem[idx];
        v_e       = {{(EW - WIDTH){v_cur[WIDTH-1]}}, v_cur};
        i_e       = {{(EW - WIDTH){i_cur[WIDTH-1]}}, i_cur};
        sum       = v_e + (i_e >>> B_SHIFT) + ((v_e * v_e) >>> FRAC_SHIFT);
        sat       = sum;
        v_upd     = V_RST;
        refr_upd  = refr_cur;
        spike_upd = 1'b0;

        // Saturate first so the threshold sees the clamped voltage.
        if (sum > MAX_E) begin
            sat = MAX_E;
        end else if (sum < MIN_E) begin
            sat = MIN_E;
        end

        if (refr_cur != '0) begin
            refr_upd = refr_cur - RW'(1);
        end else if (sat >= PEAK_E) begin
            spike_upd = 1'b1;
            refr_upd  = REFR_LOAD;
        end else begin
            v_upd = sat[WIDTH-1:0];
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            pop = pop + PW'(shadow[k]);
        end
    end

    assign busy  = (state != IDLE);
    assign v_mon = v_mem[v_mon_sel];

    // NOTE: the neuron state arrays are reset because reset must return every
    // neuron to a known voltage and current; they are built as flops, not RAM.
    // NOTE: sequential state uses non-blocking assignments only, so the
    // datapath always reads the pre-edge value (a same-edge current write to
    // the neuron being updated is therefore seen only on the next sweep).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            spike_vec <= '0;
            spike_cnt <= '0;
            done      <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k]    <= V_RST;
                cur_mem[k]  <= '0;
                refr_mem[k] <= '0;
            end
        end else begin
            // done is a single-cycle pulse and drops whenever ena is low.
            done <= 1'b0;

            if (cur_we) begin
                cur_mem[cur_addr] <= cur_data;
            end

            if (ena) begin
                case (state)
                    IDLE: begin
                        if (step) begin
                            state  <= UPDATE;
                            idx    <= '0;
                            shadow <= '0;
                        end
                    end
                    UPDATE: begin
                        v_mem[idx]    <= v_upd;
                        refr_mem[idx] <= refr_upd;
                        if (spike_upd) begin
                            shadow[idx] <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= FINISH;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                    FINISH: begin
                        spike_vec <= shadow;
                        spike_cnt <= spike_cnt + 16'(pop);
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// ---------------------------------------------------------------------------
// tb_qif_neuron_array
//   Directed bench for qif_neuron_array. The default instance (u_dut) and a
//   V_PEAK=127 instance (u_pk) share all inputs. Expected voltages are
//   hand-derived from the update equation with WIDTH=8, V_RESET=-20,
//   B_SHIFT=2, FRAC_SHIFT=4 and REFRACT=2.
//   Currents: I0=0 (later 100), I1=100, I2=0, I3=-40.
// ---------------------------------------------------------------------------
module tb_qif_neuron_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cur_we;
    logic [1:0] cur_addr;
    logic [7:0] cur_data;
    logic       step;
    logic [1:0] v_mon_sel;

    logic       busy,      pk_busy;
    logic       done,      pk_done;
    logic [3:0] spike_vec, pk_spike_vec;
    logic [15:0] spike_cnt, pk_spike_cnt;
    logic [7:0] v_mon,     pk_v_mon;

    int checks = 0;
    int errors = 0;
    int n_busy;
    int n_done;

    always #5 clk = ~clk;

    qif_neuron_array u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cur_we    (cur_we),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec),
        .spike_cnt (spike_cnt),
        .v_mon_sel (v_mon_sel),
        .v_mon     (v_mon)
    );

    qif_neuron_array #(.V_PEAK(127)) u_pk (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cur_we    (cur_we),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .step      (step),
        .busy      (pk_busy),
        .done      (pk_done),
        .spike_vec (pk_spike_vec),
        .spike_cnt (pk_spike_cnt),
        .v_mon_sel (v_mon_sel),
        .v_mon     (pk_v_mon)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        v_mon_sel = sel;
        #1;
        check(tag, {24'd0, v_mon}, {24'd0, exp});
    endtask

    task automatic check_pk_v(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        v_mon_sel = sel;
        #1;
        check(tag, {24'd0, pk_v_mon}, {24'd0, exp});
    endtask

    task automatic write_cur(input logic [1:0] a, input logic [7:0] d);
        cur_we   = 1'b1;
        cur_addr = a;
        cur_data = d;
        @(negedge clk);
        cur_we   = 1'b0;
    endtask

    // One sweep over a fixed 12-cycle window, counting busy and done cycles.
    // wr: write current during the first update edge (neuron 0 updating).
    // hold: drop ena for three edges in the middle of the sweep.
    task automatic run_sweep(input bit wr, input logic [1:0] wa, input logic [7:0] wd,
                             input bit hold);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        if (wr) begin
            cur_we   = 1'b1;
            cur_addr = wa;
            cur_data = wd;
        end
        n_busy = 0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy) n_busy++;
            if (done) n_done++;
            if (hold && k == 1) ena = 1'b0;
            if (hold && k == 4) ena = 1'b1;
            @(negedge clk);
            cur_we = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        cur_we    = 1'b0;
        cur_addr  = '0;
        cur_data  = '0;
        step      = 1'b0;
        v_mon_sel = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        for (int s = 0; s < 4; s++) check_v("rst_v", 2'(s), 8'hEC);
        check("rst_spike_vec", {28'd0, spike_vec}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_cnt", {16'd0, spike_cnt}, 32'h0);

        write_cur(2'd1, 8'd100);
        write_cur(2'd3, 8'hD8);    // -40

        // Sweep 1: V0 -20->5, V1 -20->30, V3 -20->-5
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check("s1_busy_cycles", n_busy, 5);
        check("s1_done_cycles", n_done, 1);
        check_v("s1_v0", 2'd0, 8'h05);
        check_v("s1_v1", 2'd1, 8'd30);
        check_v("s1_v3", 2'd3, 8'hFB);
        check("s1_spike_vec", {28'd0, spike_vec}, 32'h0);
        check_pk_v("s1_pk_v1", 2'd1, 8'd30);

        // Sweep 2: V1 raw 111 >= 50 spikes; the V_PEAK=127 copy holds 111
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check_v("s2_v0", 2'd0, 8'h06);
        check_v("s2_v1", 2'd1, 8'hEC);
        check_v("s2_v3", 2'd3, 8'hF2);
        check("s2_spike_vec", {28'd0, spike_vec}, 32'h2);
        check("s2_cnt", {16'd0, spike_cnt}, 32'd1);
        check_pk_v("s2_pk_v1", 2'd1, 8'h6F);
        check("s2_pk_spike_vec", {28'd0, pk_spike_vec}, 32'h0);

        // Sweep 3: V1 refractory; pk copy raw 906 saturates to 127 and spikes
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check_v("s3_v0", 2'd0, 8'h08);
        check_v("s3_v1", 2'd1, 8'hEC);
        check_v("s3_v3", 2'd3, 8'hF4);
        check("s3_spike_vec", {28'd0, spike_vec}, 32'h0);
        check("s3_cnt", {16'd0, spike_cnt}, 32'd1);
        check_pk_v("s3_pk_v1", 2'd1, 8'hEC);
        check("s3_pk_spike_vec", {28'd0, pk_spike_vec}, 32'h2);
        check("s3_pk_cnt", {16'd0, pk_spike_cnt}, 32'd1);

        // Sweep 4: V1 still refractory
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check_v("s4_v0", 2'd0, 8'd12);
        check_v("s4_v1", 2'd1, 8'hEC);
        check_v("s4_v3", 2'd3, 8'hF3);

        // Sweep 5: V1 out of refractory, back to 30
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check_v("s5_v0", 2'd0, 8'd21);
        check_v("s5_v1", 2'd1, 8'd30);
        check("s5_spike_vec", {28'd0, spike_vec}, 32'h0);

        // Sweep 6: I0<=100 lands on the edge updating neuron 0, which must use
        // the old I0=0 (48, no spike). V1 spikes again.
        run_sweep(1'b1, 2'd0, 8'd100, 1'b0);
        check_v("s6_v0_old_cur", 2'd0, 8'd48);
        check("s6_spike_vec", {28'd0, spike_vec}, 32'h2);
        check("s6_cnt", {16'd0, spike_cnt}, 32'd2);

        // Sweep 7 with ena low for three edges: sweep stretches by 3 cycles.
        // V0 and V2 saturate and spike; V1 refractory.
        run_sweep(1'b0, 2'd0, 8'd0, 1'b1);
        check("s7_busy_cycles", n_busy, 8);
        check("s7_done_cycles", n_done, 1);
        check_v("s7_v0", 2'd0, 8'hEC);
        check_v("s7_v2", 2'd2, 8'hEC);
        check_v("s7_v3", 2'd3, 8'hF3);
        check("s7_spike_vec", {28'd0, spike_vec}, 32'h5);
        check("s7_cnt", {16'd0, spike_cnt}, 32'd4);

        // step held high for 18 edges: sweeps accepted every 6 cycles -> 3
        step   = 1'b1;
        n_busy = 0;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 17) step = 1'b0;
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("b2b_done_pulses", n_done, 3);
        check("b2b_busy_cycles", n_busy, 15);

        // Reset asserted on the second update edge of a sweep: no done
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("mid_rst_done", n_done, 0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_cnt", {16'd0, spike_cnt}, 32'h0);
        check("mid_rst_spike_vec", {28'd0, spike_vec}, 32'h0);
        for (int s = 0; s < 4; s++) check_v("mid_rst_v", 2'(s), 8'hEC);

        // Fresh behaviour: currents cleared, every neuron -20 -> 5
        run_sweep(1'b0, 2'd0, 8'd0, 1'b0);
        check("post_rst_busy_cycles", n_busy, 5);
        check("post_rst_done_cycles", n_done, 1);
        check_v("post_rst_v1", 2'd1, 8'h05);
        check_v("post_rst_v3", 2'd3, 8'h05);
        check("post_rst_spike_vec", {28'd0, spike_vec}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
